// File: rtl/seq_checker_pkg.sv
// Shared types and constants for the button-sequence checker.
package seq_checker_pkg;

  localparam int CODE_W  = 2;  // bits per button code
  localparam int PROG_W  = 4;  // width of progress / sequence length
  localparam int NUM_BTN = 4;  // number of buttons

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_BTN = 2'd1,
    ST_FINISH   = 2'd2
  } state_e;

  // Decoded view of one cycle of button pulses.
  typedef struct packed {
    logic              valid;  // exactly one button pressed
    logic              multi;  // more than one button pressed
    logic [CODE_W-1:0] code;   // index of the pressed button when valid
  } press_t;

  // Classify a button pulse vector as none / single / multiple press.
  function automatic press_t decode_press(input logic [NUM_BTN-1:0] btn);
    press_t r;
    r = '0;
    case (btn)
      4'b0000: ;
      4'b0001: begin r.valid = 1'b1; r.code = 2'd0; end
      4'b0010: begin r.valid = 1'b1; r.code = 2'd1; end
      4'b0100: begin r.valid = 1'b1; r.code = 2'd2; end
      4'b1000: begin r.valid = 1'b1; r.code = 2'd3; end
      default: r.multi = 1'b1;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/seq_checker_tick.sv
// Inactivity timer: counts tick pulses, flags the tick that reaches TIMEOUT_TICKS.
module tick_timer #(
  parameter int TIMEOUT_TICKS = 1000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,   // restart the count; wins over en_i
  input  logic en_i,    // one tick pulse to count
  output logic tc_o     // this tick is the TIMEOUT_TICKS-th since the last clear
);

  localparam int CNT_W = $clog2(TIMEOUT_TICKS + 1);
  localparam logic [CNT_W-1:0] LAST_VAL = CNT_W'(TIMEOUT_TICKS - 1);
  localparam logic [CNT_W-1:0] SAT_VAL  = CNT_W'(TIMEOUT_TICKS);

  logic [CNT_W-1:0] count_q, count_d;

  // Terminal count is combinational so the owner can react on the same edge
  // as the final tick.
  assign tc_o = en_i && (count_q == LAST_VAL);

  // Next count: clear has priority, otherwise count ticks up to saturation.
  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i && (count_q != SAT_VAL)) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/seq_checker.sv
// Button-sequence checker: compares single-button presses against a latched
// pattern, reporting match, mismatch or inactivity timeout per round.
module seq_checker
  import seq_checker_pkg::*;
#(
  parameter int MAX_LEN       = 8,
  parameter int TIMEOUT_TICKS = 1000
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic [NUM_BTN-1:0]         btn_pulse,
  input  logic [CODE_W*MAX_LEN-1:0]  pattern,
  input  logic [PROG_W-1:0]          seq_len,
  input  logic                       tick,
  output logic                       busy,
  output logic [PROG_W-1:0]          progress,
  output logic                       done,
  output logic                       match,
  output logic                       mismatch,
  output logic                       timeout_o
);

  localparam logic [PROG_W-1:0] MAX_LEN_W = PROG_W'(MAX_LEN);

  state_e                      state_q, state_d;
  logic [CODE_W*MAX_LEN-1:0]   pat_q, pat_d;
  logic [PROG_W-1:0]           len_q, len_d;
  logic [PROG_W-1:0]           prog_q, prog_d;
  logic                        busy_q, busy_d;
  logic                        done_q, done_d;
  logic                        match_q, match_d;
  logic                        mismatch_q, mismatch_d;
  logic                        timeout_q, timeout_d;

  logic                        timer_clr;
  logic                        timer_en;
  logic                        timer_tc;
  press_t                      press;
  logic [CODE_W-1:0]           expected_code;
  logic [PROG_W-1:0]           len_clamped;

  // Ticks only matter while waiting for a press; a Start in the same cycle
  // restarts the timer instead.
  assign timer_en = tick && (state_q == ST_WAIT_BTN) && !start;

  tick_timer #(
    .TIMEOUT_TICKS(TIMEOUT_TICKS)
  ) u_tick_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (timer_clr),
    .en_i  (timer_en),
    .tc_o  (timer_tc)
  );

  // Decode buttons, pick the pattern entry for the current position, clamp length.
  always_comb begin
    press         = decode_press(btn_pulse);
    expected_code = '0;
    for (int k = 0; k < MAX_LEN; k++) begin
      if (PROG_W'(k) == prog_q) begin
        expected_code = pat_q[k*CODE_W +: CODE_W];
      end
    end
    len_clamped = (seq_len > MAX_LEN_W) ? MAX_LEN_W : seq_len;
  end

  // Round control: Start restarts from any state; otherwise the FSM walks
  // WAIT_BTN -> FINISH -> IDLE, ending a round with exactly one result flag.
  always_comb begin
    state_d    = state_q;
    pat_d      = pat_q;
    len_d      = len_q;
    prog_d     = prog_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    match_d    = match_q;
    mismatch_d = mismatch_q;
    timeout_d  = timeout_q;
    timer_clr  = 1'b0;

    if (start) begin
      pat_d      = pattern;
      len_d      = len_clamped;
      prog_d     = '0;
      match_d    = 1'b0;
      mismatch_d = 1'b0;
      timeout_d  = 1'b0;
      timer_clr  = 1'b1;
      if (len_clamped == '0) begin
        state_d = ST_FINISH;
        match_d = 1'b1;
        done_d  = 1'b1;
        busy_d  = 1'b0;
      end else begin
        state_d = ST_WAIT_BTN;
        busy_d  = 1'b1;
      end
    end else begin
      case (state_q)
        ST_WAIT_BTN: begin
          if (press.multi) begin
            mismatch_d = 1'b1;
            done_d     = 1'b1;
            busy_d     = 1'b0;
            state_d    = ST_FINISH;
          end else if (press.valid) begin
            // A press always restarts the inactivity window, even alongside a tick.
            timer_clr = 1'b1;
            if (press.code == expected_code) begin
              prog_d = prog_q + PROG_W'(1);
              if ((prog_q + PROG_W'(1)) == len_q) begin
                match_d = 1'b1;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = ST_FINISH;
              end
            end else begin
              mismatch_d = 1'b1;
              done_d     = 1'b1;
              busy_d     = 1'b0;
              state_d    = ST_FINISH;
            end
          end else if (timer_tc) begin
            timeout_d = 1'b1;
            done_d    = 1'b1;
            busy_d    = 1'b0;
            state_d   = ST_FINISH;
          end
        end
        ST_FINISH: state_d = ST_IDLE;
        default:   state_d = ST_IDLE;
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      pat_q      <= '0;
      len_q      <= '0;
      prog_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      match_q    <= 1'b0;
      mismatch_q <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      pat_q      <= pat_d;
      len_q      <= len_d;
      prog_q     <= prog_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      match_q    <= match_d;
      mismatch_q <= mismatch_d;
      timeout_q  <= timeout_d;
    end
  end

  assign busy      = busy_q;
  assign progress  = prog_q;
  assign done      = done_q;
  assign match     = match_q;
  assign mismatch  = mismatch_q;
  assign timeout_o = timeout_q;

endmodule

// File: tb/tb_seq_checker.sv
// Directed bench for seq_checker with hand-computed expectations.
module tb_seq_checker;

  localparam int MAX_LEN = 8;
  localparam int TMO     = 4;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic                   start;
  logic [3:0]             btn_pulse;
  logic [2*MAX_LEN-1:0]   pattern;
  logic [3:0]             seq_len;
  logic                   tick;
  logic                   busy;
  logic [3:0]             progress;
  logic                   done;
  logic                   match;
  logic                   mismatch;
  logic                   timeout_o;

  int errors = 0;
  int checks = 0;

  seq_checker #(
    .MAX_LEN       (MAX_LEN),
    .TIMEOUT_TICKS (TMO)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .btn_pulse (btn_pulse),
    .pattern   (pattern),
    .seq_len   (seq_len),
    .tick      (tick),
    .busy      (busy),
    .progress  (progress),
    .done      (done),
    .match     (match),
    .mismatch  (mismatch),
    .timeout_o (timeout_o)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge, then settle before sampling; pulses drop after the edge.
  task automatic cyc();
    @(posedge clk);
    #1;
    start     = 1'b0;
    btn_pulse = 4'b0000;
    tick      = 1'b0;
  endtask

  // {busy, done, match, mismatch, timeout_o, progress}
  function automatic logic [8:0] outs();
    return {busy, done, match, mismatch, timeout_o, progress};
  endfunction

  task automatic do_start(input logic [15:0] pat, input logic [3:0] len);
    pattern = pat;
    seq_len = len;
    start   = 1'b1;
    cyc();
  endtask

  task automatic press(input logic [3:0] b);
    btn_pulse = b;
    cyc();
  endtask

  task automatic one_tick();
    tick = 1'b1;
    cyc();
    cyc();
  endtask

  // Entries 2,0,1 at positions 0,1,2.
  localparam logic [15:0] PAT_A = 16'h0012;

  initial begin
    rst_n = 1'b0; start = 1'b0; btn_pulse = '0; pattern = '0; seq_len = '0; tick = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outs", 32'(outs()), 32'h000);
    rst_n = 1'b1;

    // Correct three-entry sequence.
    do_start(PAT_A, 4'd3);
    chk("a_start", 32'(outs()), {23'd0, 9'b1_0000_0000});
    press(4'b0100); chk("a_prog1", 32'(progress), 32'd1);
    press(4'b0001); chk("a_prog2", 32'(progress), 32'd2);
    press(4'b0010);
    chk("a_end", 32'(outs()), {23'd0, 9'b0_1100_0011});
    cyc();
    chk("a_hold", 32'(outs()), {23'd0, 9'b0_0100_0011});

    // Wrong second press.
    do_start(PAT_A, 4'd3);
    press(4'b0100); chk("b_prog1", 32'(progress), 32'd1);
    press(4'b1000);
    chk("b_mismatch", 32'(outs()), {23'd0, 9'b0_1010_0001});
    cyc();

    // Timeout after four ticks with no press.
    do_start(PAT_A, 4'd3);
    repeat (3) one_tick();
    chk("c_no_tmo_yet", 32'(outs()), {23'd0, 9'b1_0000_0000});
    tick = 1'b1; cyc();
    chk("c_timeout", 32'(outs()), {23'd0, 9'b0_1001_0000});
    cyc();

    // Press coincident with the 4th tick wins and restarts the window.
    do_start(PAT_A, 4'd3);
    repeat (3) one_tick();
    tick = 1'b1; btn_pulse = 4'b0100; cyc();
    chk("d_press_tick", 32'(outs()), {23'd0, 9'b1_0000_0001});
    repeat (3) one_tick();
    chk("d_window_reset", 32'(outs()), {23'd0, 9'b1_0000_0001});
    tick = 1'b1; cyc();
    chk("d_timeout", 32'(outs()), {23'd0, 9'b0_1001_0001});
    cyc();

    // Two buttons at once.
    do_start(PAT_A, 4'd3);
    press(4'b0011);
    chk("e_multi", 32'(outs()), {23'd0, 9'b0_1010_0000});
    cyc(); cyc();

    // Buttons and ticks in IDLE change nothing.
    btn_pulse = 4'b0100; tick = 1'b1; cyc();
    chk("f_idle_ignore", 32'(outs()), {23'd0, 9'b0_0010_0000});

    // Zero-length sequence matches immediately.
    do_start(PAT_A, 4'd0);
    chk("g_len0", 32'(outs()), {23'd0, 9'b0_1100_0000});
    cyc();

    // Over-long length clamps to MAX_LEN.
    do_start(16'h0000, 4'd15);
    repeat (7) press(4'b0001);
    chk("g_clamp_7", 32'(outs()), {23'd0, 9'b1_0000_0111});
    press(4'b0001);
    chk("g_clamp_8", 32'(outs()), {23'd0, 9'b0_1100_1000});
    cyc();

    // Asynchronous reset mid-round.
    do_start(PAT_A, 4'd3);
    press(4'b0100);
    press(4'b0001);
    chk("h_prog2", 32'(progress), 32'd2);
    #2 rst_n = 1'b0;
    #1;
    chk("h_async_rst", 32'(outs()), 32'h000);
    start = 1'b1;
    @(posedge clk); #1;
    chk("h_start_in_rst", 32'(outs()), 32'h000);
    rst_n = 1'b1;
    do_start(PAT_A, 4'd3);
    chk("h_first_start", 32'(outs()), {23'd0, 9'b1_0000_0000});

    // Restart mid-round, then complete the new round.
    press(4'b0100);
    press(4'b0001);
    do_start(PAT_A, 4'd3);
    chk("i_restart", 32'(outs()), {23'd0, 9'b1_0000_0000});
    press(4'b0100);
    press(4'b0001);
    press(4'b0010);
    chk("i_complete", 32'(outs()), {23'd0, 9'b0_1100_0011});
    cyc();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
